reg_scoreboard: RTL

- Writer-side companion to the decode-stage stall logic.
- Records every in-flight destination register as instructions leave decode, and shifts those records through the pipeline.
- Retires each record at writeback.
- From this tracked state it produces the decode stall, a pending-register bitmask, an in-flight count and a saturating stall-cycle counter.

---
 rtl/reg_scoreboard_if.sv | 33 +++
 rtl/reg_scoreboard.sv | 108 ++++++++++
 2 files changed

// File: rtl/reg_scoreboard_if.sv
// Decode/pipeline interface of the register scoreboard.
// The master side (pipeline control) drives issue, source-select and advance/flush;
// the slave side (scoreboard) returns stall and the tracked-state summaries.
interface reg_scoreboard_if #(
  parameter int NREGS = 32,
  parameter int REGW  = 5,
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              issue_valid;
  logic              issue_wen;
  logic [REGW-1:0]   issue_wsel;
  logic [REGW-1:0]   rsel1;
  logic [REGW-1:0]   rsel2;
  logic              advance;
  logic              flush;
  logic              stall;
  logic [NREGS-1:0]  pending;
  logic [CW-1:0]     inflight;
  logic [CNTW-1:0]   stall_cnt;

  modport master (
    output issue_valid, issue_wen, issue_wsel, rsel1, rsel2, advance, flush,
    input  stall, pending, inflight, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_wen, issue_wsel, rsel1, rsel2, advance, flush,
    output stall, pending, inflight, stall_cnt
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight destination registers between decode
// and writeback (slot 0 = EX, slot DEPTH-1 = MEM), raises the decode RAW stall
// and reports pending registers, in-flight count and a saturating stall counter.
// Writeback is write-before-read, so the record leaving the last slot is not
// considered for hazards.
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int REGW  = 5,
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input logic             clk,
  input logic             n_rst,
  reg_scoreboard_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld_r;
  logic [REGW-1:0]  wsel_r [DEPTH];
  logic [CNTW-1:0]  cnt_r;

  logic             hit_s;
  logic             stall_s;
  logic             issue_ok_s;
  logic [NREGS-1:0] pending_s;
  logic [CW-1:0]    inflight_s;

  // Number of set bits in the slot valid vector.
  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CW-1:0] n;
    n = {CW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  // Source-operand match against any valid, non-zero tracked destination.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_r[i] && (wsel_r[i] != {REGW{1'b0}}) &&
          ((wsel_r[i] == bus.rsel1) || (wsel_r[i] == bus.rsel2))) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Stall only for a real decode instruction; issue is blocked by stall or flush.
  always_comb begin
    stall_s    = bus.issue_valid & hit_s;
    issue_ok_s = bus.issue_valid & bus.issue_wen &
                 (bus.issue_wsel != {REGW{1'b0}}) & ~stall_s & ~bus.flush;
  end

  // One-hot OR of valid destinations; register 0 never reads as pending.
  always_comb begin
    pending_s = {NREGS{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_r[i]) begin
        pending_s[wsel_r[i]] = 1'b1;
      end else begin
        pending_s = pending_s;
      end
    end
    pending_s[0] = 1'b0;
  end

  // In-flight count.
  always_comb begin
    inflight_s = popcount(vld_r);
  end

  // Slot shift on advance; flush kills the record that is (or was) in EX.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        wsel_r[i] <= {REGW{1'b0}};
      end
    end else if (bus.advance) begin
      vld_r[0]  <= issue_ok_s;
      wsel_r[0] <= issue_ok_s ? bus.issue_wsel : {REGW{1'b0}};
      for (int i = 1; i < DEPTH; i++) begin
        vld_r[i]  <= ((i == 1) && bus.flush) ? 1'b0 : vld_r[i-1];
        wsel_r[i] <= wsel_r[i-1];
      end
    end else if (bus.flush) begin
      vld_r[0] <= 1'b0;
    end
  end

  // Saturating count of cycles where decode stalls while the pipe advances.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_r <= {CNTW{1'b0}};
    end else if (stall_s && bus.advance && (cnt_r != {CNTW{1'b1}})) begin
      cnt_r <= cnt_r + CNTW'(1);
    end
  end

  assign bus.stall     = stall_s;
  assign bus.pending   = pending_s;
  assign bus.inflight  = inflight_s;
  assign bus.stall_cnt = cnt_r;
endmodule
